branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch target buffer (BTB) that drives the program counter's pred_branch and pred_branch_addr inputs.
- Looks up the current fetch address combinationally against a direct-mapped table of 2-bit saturating counters and stored targets.
- Is trained by branch resolution from execute.
- Also counts resolved mispredictions for performance monitoring.

Parameters:
- word_width, 32, address/target width in bits
- index_bits, 4, log2 of BTB entries (default 16 entries)
- reset_ctr, 2'b01, counter value loaded into every entry on reset (weakly not-taken)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-low; reset==0 at posedge clears state
- inst_addr  input  word_width  current fetch address (PC register output)
- stall  input  1  fetch stalled this cycle
- redirect  input  1  resolved-branch redirect to PC this cycle
- pred_branch  output  1  predict taken; PC loads pred_branch_addr
- pred_branch_addr  output  word_width  predicted target
- upd_valid  input  1  a branch resolved this cycle
- upd_pc  input  word_width  address of the resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  word_width  actual target
- upd_pred_taken  input  1  prediction made for that branch at fetch
- mispredict_count  output  word_width  running count of mispredictions

Behaviour:
Address split:
- index = addr[index_bits+1:2]
- tag = addr[word_width-1:index_bits+2]
- addr[1:0] ignored.

Entry state:
- valid (1), tag, target (word_width), ctr (2).

Lookup (combinational, zero latency):
- hit = valid[idx] & tag match.
- pred_branch = hit & ctr[1] & ~stall & ~redirect & reset.
- This is forced 0 whenever reset==0, stall==1 or redirect==1, because the PC gives pred_branch priority over stall and branch.
- pred_branch_addr = target[idx] when hit, else 0.

Update (registered, visible to lookups from the next cycle):
- upd_valid & entry hit:
  - ctr saturating increment if upd_taken, else saturating decrement.
  - Saturation: 11 stays 11; 00 stays 00.
  - target <= upd_target only when upd_taken.
- upd_valid & miss & upd_taken: allocate by overwriting the entry.
  - valid=1, tag=upd tag, target=upd_target, ctr=2'b10.
- upd_valid & miss & ~upd_taken: no table change.

Mispredict counter:
- Increments by 1 when upd_valid & (upd_taken != upd_pred_taken).
- Wraps modulo 2^word_width.

Simultaneous lookup and update to the same index:
- Lookup returns pre-update contents; no bypass.

Reset:
- valid all 0, ctr all reset_ctr, targets and tags 0, mispredict_count 0.
- Reset has priority over a same-cycle update; the update is dropped.
- Reset mid-operation discards all training.

Aliasing:
- Two branches with the same index and different tags evict each other.
- No replacement policy beyond overwrite.

Decomposition:
- Package bp_pkg holds:
  - typedef ctr_t (2-bit).
  - constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - functions bp_index(addr) and bp_tag(addr) parameterised by index_bits.
- One natural sub-module: bp_sat_ctr, the 2-bit saturating next-state function (inc/dec with clamp), instanced in the update path.
- Table arrays stay in branch_predictor.

Test Plan:
- Reset then lookup 0x00000040 -> pred_branch=0, mispredict_count=0.
- Update upd_pc=0x40, taken, target 0x100, pred_taken=0; next cycle inst_addr=0x40 -> pred_branch=1, pred_branch_addr=0x100, mispredict_count=1.
- Same branch resolved not-taken twice (ctr 10->01->00) -> pred_branch=0 after the first update; a third not-taken stays 00; one taken update returns it to 01 and prediction stays 0.
- Prediction hit at 0x40 with stall=1 or redirect=1 -> pred_branch=0; with both low -> 1.
- Alias: train 0x40 then allocate 0x440 (same index, 16 entries) taken to 0x200 -> lookup 0x40 misses (pred_branch=0); lookup 0x440 predicts 0x200.
- Update and lookup of 0x40 in the same cycle on an empty table -> that cycle pred_branch=0, next cycle 1; asserting reset=0 while upd_valid=1 -> table and counter stay cleared.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and address-field helpers for the branch target buffer.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Helpers work on a 64-bit zero-extended address so any word_width up to 64 fits;
  // callers truncate the result to their field width.
  function automatic logic [63:0] bp_index(input logic [63:0] addr, input int index_bits);
    logic [63:0] mask;
    mask = (64'd1 << index_bits) - 64'd1;
    return (addr >> 2) & mask;
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] addr, input int index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: increment on taken, decrement otherwise, clamped.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic inc,
  output ctr_t ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, registered training,
// and a running mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int   word_width = 32,
  parameter int   index_bits = 4,
  parameter ctr_t reset_ctr  = CTR_WNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [word_width-1:0] inst_addr,
  input  logic                  stall,
  input  logic                  redirect,
  output logic                  pred_branch,
  output logic [word_width-1:0] pred_branch_addr,
  input  logic                  upd_valid,
  input  logic [word_width-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [word_width-1:0] upd_target,
  input  logic                  upd_pred_taken,
  output logic [word_width-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << index_bits;
  localparam int TAG_W   = word_width - index_bits - 2;

  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [word_width-1:0] target_q [ENTRIES];
  logic [word_width-1:0] target_d [ENTRIES];
  ctr_t                  ctr_q    [ENTRIES];
  ctr_t                  ctr_d    [ENTRIES];
  logic [word_width-1:0] mis_cnt_q, mis_cnt_d;

  logic [index_bits-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  logic                  lk_hit, up_hit;
  ctr_t                  up_ctr_nxt;

  assign lk_idx = index_bits'(bp_index(64'(inst_addr), index_bits));
  assign lk_tag = TAG_W'(bp_tag(64'(inst_addr), index_bits));
  assign up_idx = index_bits'(bp_index(64'(upd_pc), index_bits));
  assign up_tag = TAG_W'(bp_tag(64'(upd_pc), index_bits));

  // Lookup reads current state only; a same-cycle update is not bypassed.
  assign lk_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_branch      = lk_hit && ctr_q[lk_idx][1] && !stall && !redirect && reset;
  assign pred_branch_addr = lk_hit ? target_q[lk_idx] : '0;
  assign mispredict_count = mis_cnt_q;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_sat_ctr u_sat_ctr (
    .ctr     (ctr_q[up_idx]),
    .inc     (upd_taken),
    .ctr_nxt (up_ctr_nxt)
  );

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_valid) begin
      if (up_hit) begin
        ctr_d[up_idx] = up_ctr_nxt;
        if (upd_taken) target_d[up_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WT;
      end
      if (upd_taken != upd_pred_taken) mis_cnt_d = mis_cnt_q + word_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= reset_ctr;
      end
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: one record per cycle, outputs checked pre-edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        stall, redirect;
  logic        pred_branch;
  logic [31:0] pred_branch_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .inst_addr        (inst_addr),
    .stall            (stall),
    .redirect         (redirect),
    .pred_branch      (pred_branch),
    .pred_branch_addr (pred_branch_addr),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic        stall;
    logic        redir;
    logic        uv;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        upt;
    logic        e_pred;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst_n, logic [31:0] addr, logic st, logic rd,
                              logic uv, logic [31:0] upc, logic utk, logic [31:0] utgt,
                              logic upt, logic e_pred, logic [31:0] e_addr, logic [31:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.addr = addr; v.stall = st; v.redir = rd;
    v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt; v.upt = upt;
    v.e_pred = e_pred; v.e_addr = e_addr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst_n; inst_addr = v.addr; stall = v.stall; redirect = v.redir;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.utk; upd_target = v.utgt;
    upd_pred_taken = v.upt;
  endtask

  initial begin
    vec_t v;
    //          rst addr   st rd uv upc    tk tgt    pt  pred e_addr e_cnt
    vq.push_back(mk(1, 32'h40,  0,0, 0,32'h0,  0,32'h0,  0,  0,32'h0,  0)); // 0 reset state
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 1,32'h100,0,  0,32'h0,  0)); // 1 same-cycle alloc, no bypass
    vq.push_back(mk(1, 32'h40,  0,0, 0,32'h0,  0,32'h0,  0,  1,32'h100,1)); // 2 predicted next cycle
    vq.push_back(mk(1, 32'h40,  1,0, 0,32'h0,  0,32'h0,  0,  0,32'h100,1)); // 3 stall kills
    vq.push_back(mk(1, 32'h40,  0,1, 0,32'h0,  0,32'h0,  0,  0,32'h100,1)); // 4 redirect kills
    vq.push_back(mk(1, 32'h40,  1,1, 0,32'h0,  0,32'h0,  0,  0,32'h100,1)); // 5 both
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 0,32'h0,  1,  1,32'h100,1)); // 6 NT: 10->01
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 0,32'h0,  0,  0,32'h100,2)); // 7 NT: 01->00
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 0,32'h0,  0,  0,32'h100,2)); // 8 NT: 00 stays
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 1,32'h180,0,  0,32'h100,2)); // 9 T: 00->01, new tgt
    vq.push_back(mk(1, 32'h40,  0,0, 0,32'h0,  0,32'h0,  0,  0,32'h180,3)); // 10 still not predicted
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 1,32'h180,0,  0,32'h180,3)); // 11 T: 01->10
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 1,32'h180,1,  1,32'h180,4)); // 12 T: 10->11
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 1,32'h180,1,  1,32'h180,4)); // 13 T: 11 stays
    vq.push_back(mk(1, 32'h40,  0,0, 1,32'h40, 0,32'h0,  1,  1,32'h180,4)); // 14 NT: 11->10
    vq.push_back(mk(1, 32'h40,  0,0, 0,32'h0,  0,32'h0,  0,  1,32'h180,5)); // 15 still taken
    vq.push_back(mk(1, 32'h440, 0,0, 1,32'h440,1,32'h200,0,  0,32'h0,  5)); // 16 alias alloc
    vq.push_back(mk(1, 32'h40,  0,0, 0,32'h0,  0,32'h0,  0,  0,32'h0,  6)); // 17 evicted
    vq.push_back(mk(1, 32'h440, 0,0, 0,32'h0,  0,32'h0,  0,  1,32'h200,6)); // 18 alias hit
    vq.push_back(mk(1, 32'h443, 0,0, 0,32'h0,  0,32'h0,  0,  1,32'h200,6)); // 19 low bits ignored
    vq.push_back(mk(1, 32'h80,  0,0, 1,32'h80, 0,32'h300,1,  0,32'h0,  6)); // 20 miss NT: no alloc
    vq.push_back(mk(1, 32'h80,  0,0, 1,32'h7C, 1,32'h44, 1,  0,32'h0,  7)); // 21 top index alloc
    vq.push_back(mk(1, 32'h7C,  0,0, 0,32'h0,  0,32'h0,  0,  1,32'h44, 7)); // 22 top index hit
    vq.push_back(mk(0, 32'h7C,  0,0, 1,32'h80, 1,32'h300,0,  0,32'h44, 7)); // 23 reset forces 0
    vq.push_back(mk(1, 32'h7C,  0,0, 0,32'h0,  0,32'h0,  0,  0,32'h0,  0)); // 24 training gone
    vq.push_back(mk(1, 32'h440, 0,0, 0,32'h0,  0,32'h0,  0,  0,32'h0,  0)); // 25
    vq.push_back(mk(1, 32'h80,  0,0, 0,32'h0,  0,32'h0,  0,  0,32'h0,  0)); // 26 dropped update

    v = mk(0, 32'h0, 0,0, 0,32'h0, 0,32'h0, 0, 0,32'h0, 0);
    drive(v);
    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      check($sformatf("v%0d pred_branch", i), {31'd0, pred_branch}, {31'd0, vq[i].e_pred});
      check($sformatf("v%0d pred_branch_addr", i), pred_branch_addr, vq[i].e_addr);
      check($sformatf("v%0d mispredict_count", i), mispredict_count, vq[i].e_cnt);
    end

    // Reset held over several cycles of mispredicting updates: nothing may stick.
    @(negedge clk);
    drive(mk(1, 32'h0, 0,0, 1,32'h40, 1,32'h100, 0, 0,32'h0, 0));
    @(negedge clk);
    check("seq pre-reset count", mispredict_count, 32'd1);
    reset = 1'b0; upd_pc = 32'h44; upd_target = 32'h104;
    @(negedge clk);
    upd_pc = 32'h48; upd_target = 32'h108;
    @(negedge clk);
    drive(mk(1, 32'h40, 0,0, 0,32'h0, 0,32'h0, 0, 0,32'h0, 0));
    #2;
    check("seq 0x40 after reset pred", {31'd0, pred_branch}, 32'd0);
    check("seq count after reset", mispredict_count, 32'd0);
    @(negedge clk);
    inst_addr = 32'h48;
    #2;
    check("seq 0x48 after reset addr", pred_branch_addr, 32'd0);
    check("seq 0x48 after reset pred", {31'd0, pred_branch}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
